cbus_arbiter_rr: RTL and testbench
==================================

// Module: cbus_arbiter_rr
// PURPOSE
//   Round-robin arbiter merging the cbus request streams of several cache-side
//   masters (icache, dcache/VCacheTop) onto the single cbus toward memory.
//   Sits directly downstream of the caches' creq/cresp ports. It holds a grant
//   for a whole burst (through the beat with last=1), then rotates priority.
// PARAMETERS
//   NUM_INPUTS   2   number of cbus masters (>=2); index width IDX_W=$clog2(NUM_INPUTS)
// PORTS
//   clk     in   1                    clock; all state updates on posedge
//   reset   in   1                    synchronous, active-high reset
//   ireqs   in   cbus_req_t[N]        per-master requests (valid,is_write,size,addr,strobe,data,len,burst)
//   iresps  out  cbus_resp_t[N]       per-master responses (ready,last,data)
//   oreq    out  cbus_req_t           request to memory-side cbus
//   oresp   in   cbus_resp_t          response from memory-side cbus
// BEHAVIOUR
//   Reset: state=IDLE, sel=0, last_grant=N-1 (master 0 wins first);
//     oreq='0, every iresps[i]='0. Reset mid-burst aborts the grant at once.
//   Registers: state{IDLE,BUSY}, sel[IDX_W], last_grant[IDX_W].
//   IDLE: oreq='0, all iresps='0. If any ireqs[i].valid: pick first valid i
//     scanning last_grant+1, +2, ... modulo N (wrap past N-1 to 0);
//     sel<=i, state<=BUSY. No valid -> stay IDLE.
//   BUSY: oreq=ireqs[sel] (combinational pass-through, all fields);
//     iresps[sel]=oresp; iresps[j!=sel]='0 (never ready to losers).
//     If oresp.ready && oresp.last: state<=IDLE, last_grant<=sel.
//     Otherwise hold; oresp.ready without last = one beat, stay BUSY.
//   Latency: ireq.valid to oreq.valid = 1 cycle; after the last beat, one
//     IDLE cycle before the next grant (next oreq.valid 2 cycles after last).
//   Grant is sticky: requests arriving on other inputs during BUSY wait; a
//     master dropping valid mid-burst does not release the grant (oreq.valid
//     follows it to 0; masters must hold the request until last).
//   Simultaneous valids: rotation rule only; a master that just finished
//     gets lowest priority next round -> no starvation, worst-case wait is
//     N-1 bursts.
//   Single-beat requests (len=0): last on first ready beat; same flow.
//   oresp content is never inspected except ready/last; no data buffering.
// TESTING
//   reset, no valids for 10 cycles -> oreq.valid=0, all iresps.ready=0 throughout
//   only m1 valid, len=3 (4 beats), memory ready every cycle -> oreq.valid at
//     cycle+1, iresps[1] sees 4 ready beats, last on 4th; iresps[0] stays '0
//   m0 and m1 valid in same cycle after reset -> m0 granted first (4 beats),
//     then m1 granted with oreq.valid exactly 2 cycles after m0's last beat
//   both masters continuously requesting 1-beat reads for 6 grants ->
//     grant order 0,1,0,1,0,1
//   m1 becomes valid mid-way through m0's burst -> m0 burst completes
//     uninterrupted, m1 granted next; oreq.addr switches only after m0 last
//   reset asserted on 2nd beat of m0's 4-beat burst -> next cycle oreq.valid=0,
//     state IDLE; after release with both valid, m0 is granted again

Source files
------------

// File: rtl/cbus_arbiter_rr.sv
// Round-robin arbiter merging several cache-side cbus masters onto one memory cbus.
// A grant is held for a whole burst (through the last beat), then priority rotates.

package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter_rr
    import cbus_pkg::*;
#(
    parameter int NUM_INPUTS = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  cbus_req_t  [NUM_INPUTS-1:0] ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0] iresps,
    output cbus_req_t                   oreq,
    input  cbus_resp_t                  oresp
);
    localparam int IDX_W = $clog2(NUM_INPUTS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] pick;
    logic             found;

    // First valid master after the previous winner, wrapping modulo NUM_INPUTS.
    always_comb begin
        int c;
        c     = 0;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            c = int'(last_grant) + k;
            if (c >= NUM_INPUTS) c = c - NUM_INPUTS;
            if (!found && ireqs[IDX_W'(c)].valid) begin
                found = 1'b1;
                pick  = IDX_W'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= '0;
            last_grant <= IDX_W'(NUM_INPUTS - 1);
        end else begin
            case (state)
                IDLE: if (found) begin
                    sel   <= pick;
                    state <= BUSY;
                end
                BUSY: if (oresp.ready && oresp.last) begin
                    state      <= IDLE;
                    last_grant <= sel;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pure pass-through while granted; losers never see ready.
    assign oreq = (state == BUSY) ? ireqs[sel] : '0;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_resp
        assign iresps[i] = (state == BUSY && sel == IDX_W'(i)) ? oresp : '0;
    end

endmodule

// File: tb/tb_cbus_arbiter_rr.sv
// Directed bench for cbus_arbiter_rr: a ready-every-cycle memory model plus a
// scoreboard of expected (master, beat count) per completed burst.

module tb_cbus_arbiter_rr;
    import cbus_pkg::*;

    typedef struct {
        int m;
        int beats;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset;
    cbus_req_t  [1:0]    ireqs;
    cbus_resp_t [1:0]    iresps;
    cbus_req_t           oreq;
    cbus_resp_t          oresp;

    int   checks = 0;
    int   errors = 0;
    int   beats  = 0;
    int   last_cnt = 0;
    int   mon_m;
    int   mon_n;
    exp_t q[$];
    exp_t e;
    logic [7:0] mem_cnt;

    cbus_arbiter_rr #(.NUM_INPUTS(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .ireqs  (ireqs),
        .iresps (iresps),
        .oreq   (oreq),
        .oresp  (oresp)
    );

    always #5 clk = ~clk;

    // Memory side: ready whenever a request is presented, last on beat len.
    always_comb begin
        oresp       = '0;
        oresp.ready = oreq.valid;
        oresp.last  = oreq.valid && (mem_cnt == oreq.len);
        oresp.data  = {32'hD00D0000, 24'h0, mem_cnt};
    end

    always @(posedge clk) begin
        if (reset)            mem_cnt <= '0;
        else if (oresp.ready) mem_cnt <= oresp.last ? 8'd0 : mem_cnt + 8'd1;
    end

    task automatic chk(input logic [95:0] obs, input logic [95:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic cbus_req_t mkreq(input logic [31:0] addr, input logic [7:0] len);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.size     = 3'd3;
        r.addr     = addr;
        r.strobe   = 8'hff;
        r.data     = {addr, addr};
        r.len      = len;
        r.burst    = 2'd1;
        return r;
    endfunction

    task automatic push(input int m, input int nbeats);
        exp_t x;
        x.m     = m;
        x.beats = nbeats;
        q.push_back(x);
    endtask

    // Waits (bounded) for master m's last beat, then steps just past the edge.
    task automatic wait_last(input int m);
        int n;
        n = 0;
        while (!(oresp.ready && oresp.last && iresps[m].ready) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(n < 60, 1'b1, "last_beat_timeout");
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: one responder per beat, data routed intact, order/length per burst.
    always @(negedge clk) begin
        if (reset) begin
            beats = 0;
        end else if (oresp.ready) begin
            mon_m = -1;
            mon_n = 0;
            for (int i = 0; i < 2; i++)
                if (iresps[i].ready) begin
                    mon_m = i;
                    mon_n++;
                end
            chk(mon_n, 1, "one_master_ready");
            beats++;
            if (mon_m >= 0) begin
                chk(iresps[mon_m].data, oresp.data, "resp_data");
                chk(iresps[1-mon_m], '0, "loser_resp_zero");
            end
            if (oresp.last) begin
                chk(q.size() > 0, 1'b1, "burst_expected");
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk(mon_m, e.m, "grant_order");
                    chk(beats, e.beats, "beat_count");
                end
                beats = 0;
                last_cnt++;
            end
        end
    end

    initial begin
        int n;
        int base;
        reset = 1'b1;
        ireqs = '0;

        // Reset state and quiet bus.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(oreq, '0, "reset_oreq");
        chk(iresps, '0, "reset_iresps");
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk(oreq.valid, 1'b0, "idle_oreq_valid");
            chk({iresps[1].ready, iresps[0].ready}, 2'b00, "idle_ready");
        end

        // Lone m1, 4-beat burst: valid one cycle after request.
        @(posedge clk); #1;
        ireqs[1] = mkreq(32'h100, 8'd3);
        push(1, 4);
        @(negedge clk);
        chk(oreq.valid, 1'b0, "m1_same_cycle");
        @(negedge clk);
        chk(oreq.valid, 1'b1, "m1_latency");
        chk(oreq.addr, 32'h100, "m1_addr");
        chk(iresps[0], '0, "m0_resp_zero");
        wait_last(1);
        ireqs[1].valid = 1'b0;

        // Simultaneous valids after reset: m0 first, m1 two cycles after m0 last.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        ireqs[0] = mkreq(32'h200, 8'd3);
        ireqs[1] = mkreq(32'h300, 8'd3);
        push(0, 4);
        push(1, 4);
        @(negedge clk);
        wait_last(0);
        ireqs[0].valid = 1'b0;
        @(negedge clk);
        chk(oreq.valid, 1'b0, "gap_after_last");
        @(negedge clk);
        chk(oreq.valid, 1'b1, "m1_after_gap");
        chk(oreq.addr, 32'h300, "m1_after_gap_addr");
        wait_last(1);
        ireqs[1].valid = 1'b0;

        // Continuous single-beat requests alternate 0,1,0,1,0,1.
        ireqs[0] = mkreq(32'h400, 8'd0);
        ireqs[1] = mkreq(32'h500, 8'd0);
        for (int i = 0; i < 3; i++) begin
            push(0, 1);
            push(1, 1);
        end
        base = last_cnt;
        n = 0;
        while (last_cnt < base + 6 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(n < 100, 1'b1, "alternate_timeout");
        @(posedge clk); #1;
        ireqs[0].valid = 1'b0;
        ireqs[1].valid = 1'b0;

        // m1 arrives mid-burst: m0's address holds until its last beat.
        ireqs[0] = mkreq(32'h600, 8'd3);
        push(0, 4);
        @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk(oreq.addr, 32'h600, "sticky_addr");
            if (b == 1) begin
                ireqs[1] = mkreq(32'h700, 8'd3);
                push(1, 4);
            end
        end
        @(posedge clk); #1;
        ireqs[0].valid = 1'b0;
        @(negedge clk);
        chk(oreq.valid, 1'b0, "sticky_gap");
        @(negedge clk);
        chk(oreq.addr, 32'h700, "switch_addr");
        wait_last(1);
        ireqs[1].valid = 1'b0;

        // Reset on the second beat aborts the burst; m0 wins again afterwards.
        ireqs[0] = mkreq(32'h800, 8'd3);
        @(negedge clk);
        @(negedge clk);
        chk(oreq.valid, 1'b1, "abort_beat1");
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk(oreq.valid, 1'b0, "abort_oreq");
        chk(iresps, '0, "abort_iresps");
        ireqs[1] = mkreq(32'h900, 8'd3);
        @(posedge clk); #1 reset = 1'b0;
        push(0, 4);
        push(1, 4);
        @(negedge clk);
        chk(oreq.valid, 1'b0, "post_reset_idle");
        @(negedge clk);
        chk(oreq.addr, 32'h800, "post_reset_m0");
        wait_last(0);
        ireqs[0].valid = 1'b0;
        wait_last(1);
        ireqs[1].valid = 1'b0;
        repeat (2) @(negedge clk);
        chk(q.size(), 0, "scoreboard_drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
